mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Two-requester arbiter and sequencer for the single external memory bus (address, read/write strobes, data).
- Lets the CPU data port (requester 0) and a loader/debug DMA port (requester 1) share one memory.
- Round-robin grant, fixed-latency wait states, registered strobes and a one-cycle ack per transaction.
- Sits between the CPU/loader and the memory model; its write strobe and data feed the existing write-capture logic.

Parameters:
ADDR_WIDTH, 20, memory address width
DATA_WIDTH, 16, memory data width
WAIT_CYCLES, 2, extra memory wait states per access (0 allowed)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
r0_req  input  1  requester 0 access request
r0_we  input  1  requester 0: 1 = write, 0 = read
r0_addr  input  ADDR_WIDTH  requester 0 address
r0_wdata  input  DATA_WIDTH  requester 0 write data
r0_rdata  output  DATA_WIDTH  requester 0 read data, registered
r0_ack  output  1  requester 0 transaction complete, one-cycle pulse
r1_req, r1_we, r1_addr, r1_wdata, r1_rdata, r1_ack  same as r0_*, for requester 1
mem_addr  output  ADDR_WIDTH  memory address
mem_wdata  output  DATA_WIDTH  memory write data
mem_rdata  input  DATA_WIDTH  memory read data
mem_read  output  1  memory read strobe
mem_write  output  1  memory write strobe
busy  output  1  high in ACCESS and ACK states
owner  output  1  index of the current or last granted requester

Behaviour:
- Reset values: all outputs 0, except owner = 1. State = IDLE. Round-robin pointer last = 1, so r0 wins the first tie.
- All outputs are registered.
- Reset asserted mid-transaction:
  - Returns to IDLE immediately.
  - Drops mem_read/mem_write asynchronously.
  - No ack is issued; rdata registers clear to 0.
- FSM states: IDLE, ACCESS, ACK.
- IDLE:
  - req inputs are sampled only in this state.
  - Only one req high: grant it.
  - Both high: grant the requester != last.
  - On grant, latch we/addr/wdata into mem_addr/mem_wdata and an internal we register, set owner, load counter = WAIT_CYCLES, go to ACCESS.
  - No req: stay in IDLE.
- ACCESS:
  - mem_read = !we, mem_write = we, asserted for exactly WAIT_CYCLES+1 consecutive cycles.
  - mem_addr/mem_wdata held stable throughout.
  - Counter decrements each cycle. When counter == 0 and the access is a read, capture mem_rdata into the owner's rdata register. Then go to ACK.
  - Requester input changes during ACCESS are ignored.
- ACK:
  - Owner's ack = 1 for exactly one cycle; strobes are 0.
  - last <= owner; next state is IDLE.
- Total latency, req high in IDLE (cycle 0) to ack: ack is high in cycle WAIT_CYCLES+2. With WAIT_CYCLES=2, ack is at cycle 4.
- Minimum spacing between transactions is one IDLE cycle.
- Requester handshake:
  - Hold req and its fields stable until ack.
  - Deassert req on the same edge ack is sampled.
  - req still high in the following IDLE cycle is treated as a new transaction and arbitrated normally.
- A waiting requester is granted no later than the next transaction, so neither requester can starve.
- rdata holds its value until the next completed read by the same requester. Writes never change rdata.
- mem_addr/mem_wdata keep their last values in IDLE and ACK.
- mem_read and mem_write are never both 1.
- The unused requester's ack is always 0 during a transaction.
- Counter width = max(1, clog2(WAIT_CYCLES+1)).

Test Plan:
- Single read, WAIT_CYCLES=2:
  - Stimulus: r0 reads 0x00010, memory returns 0xBEEF.
  - Required: mem_read high cycles 1–3 with mem_addr=0x00010; r0_ack high cycle 4 only; r0_rdata=0xBEEF; r1_ack stays 0.
- Simultaneous requests after reset:
  - Stimulus: r0 and r1 request together.
  - Required: r0 served first, then r1 (owner 0 then 1).
  - Continue: both kept requesting.
  - Required: grants alternate 0,1,0,1.
- Write then read, r1:
  - Stimulus: r1 writes 0x1234 to 0x0ABCD, then reads 0x0ABCD.
  - Required: mem_write high 3 cycles with mem_wdata=0x1234; r1_rdata stays unchanged until the read; read returns 0x1234; mem_read and mem_write never overlap.
- WAIT_CYCLES=0:
  - Stimulus: single read by r0.
  - Required: ack at cycle 2 and mem_read high exactly 1 cycle.
  - Stimulus: back-to-back requests from r0.
  - Required: one IDLE cycle between them.
- Reset mid-access:
  - Stimulus: assert reset during cycle 2 of an r0 read.
  - Required: mem_read=0 immediately; no ack; rdata=0; owner=1; after release, a fresh r0 request completes normally.
- Field change ignored:
  - Stimulus: r0 changes r0_addr from 0x00001 to 0x00002 during ACCESS.
  - Required: mem_addr stays 0x00001 until the transaction ends.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: two-requester round-robin arbiter and sequencer for the
// single external memory bus, with fixed wait states and a one-cycle ack.
//
// Ports:
//   clk, reset            rising-edge clock, async active-high reset
//   rN_req/we/addr/wdata  requester N access request and its fields
//   rN_rdata, rN_ack      registered read data, one-cycle completion pulse
//   mem_addr/mem_wdata    registered memory address and write data
//   mem_rdata             memory read data, sampled on the last strobe cycle
//   mem_read/mem_write    registered memory strobes, never both high
//   busy                  high while a transaction is in ACCESS or ACK
//   owner                 current or last granted requester
module mem_bus_arbiter #(
    parameter int ADDR_WIDTH  = 20,
    parameter int DATA_WIDTH  = 16,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  r0_req,
    input  logic                  r0_we,
    input  logic [ADDR_WIDTH-1:0] r0_addr,
    input  logic [DATA_WIDTH-1:0] r0_wdata,
    output logic [DATA_WIDTH-1:0] r0_rdata,
    output logic                  r0_ack,
    input  logic                  r1_req,
    input  logic                  r1_we,
    input  logic [ADDR_WIDTH-1:0] r1_addr,
    input  logic [DATA_WIDTH-1:0] r1_wdata,
    output logic [DATA_WIDTH-1:0] r1_rdata,
    output logic                  r1_ack,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic                  busy,
    output logic                  owner
);

    localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_ACK
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  we_q, we_d;
    logic                  last_q, last_d;
    logic                  owner_q, owner_d;
    logic                  busy_q, busy_d;
    logic                  rd_q, rd_d;
    logic                  wr_q, wr_d;
    logic                  ack0_q, ack0_d;
    logic                  ack1_q, ack1_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d;
    logic [DATA_WIDTH-1:0] rdata1_q, rdata1_d;

    logic grant_valid;
    logic grant_sel;
    logic grant_we;

    // On a tie the requester that was not served last wins.
    always_comb begin
        grant_valid = r0_req | r1_req;
        if (r0_req && r1_req) begin
            grant_sel = ~last_q;
        end else begin
            grant_sel = r1_req;
        end
        grant_we = grant_sel ? r1_we : r0_we;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        we_d     = we_q;
        last_d   = last_q;
        owner_d  = owner_q;
        busy_d   = busy_q;
        rd_d     = rd_q;
        wr_d     = wr_q;
        ack0_d   = 1'b0;
        ack1_d   = 1'b0;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;

        unique case (state_q)
            S_IDLE: begin
                if (grant_valid) begin
                    state_d = S_ACCESS;
                    owner_d = grant_sel;
                    we_d    = grant_we;
                    addr_d  = grant_sel ? r1_addr : r0_addr;
                    wdata_d = grant_sel ? r1_wdata : r0_wdata;
                    cnt_d   = CNT_LOAD;
                    rd_d    = ~grant_we;
                    wr_d    = grant_we;
                    busy_d  = 1'b1;
                end
            end
            S_ACCESS: begin
                // Strobes stay up until the counter expires; data is
                // taken on that final strobe cycle.
                if (cnt_q == '0) begin
                    state_d = S_ACK;
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    ack0_d  = ~owner_q;
                    ack1_d  = owner_q;
                    if (!we_q) begin
                        if (owner_q) begin
                            rdata1_d = mem_rdata;
                        end else begin
                            rdata0_d = mem_rdata;
                        end
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_ACK: begin
                state_d = S_IDLE;
                last_d  = owner_q;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                rd_d    = 1'b0;
                wr_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            we_q     <= 1'b0;
            last_q   <= 1'b1;
            owner_q  <= 1'b1;
            busy_q   <= 1'b0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            we_q     <= we_d;
            last_q   <= last_d;
            owner_q  <= owner_d;
            busy_q   <= busy_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            ack0_q   <= ack0_d;
            ack1_q   <= ack1_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    assign r0_rdata  = rdata0_q;
    assign r1_rdata  = rdata1_q;
    assign r0_ack    = ack0_q;
    assign r1_ack    = ack1_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_read  = rd_q;
    assign mem_write = wr_q;
    assign busy      = busy_q;
    assign owner     = owner_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: drives two arbiters (2 and 0 wait states) with
// directed transactions and checks them against a transaction-level model.
module tb_mem_bus_arbiter;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic chk_en = 1'b0;
    int   n_cmp = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    logic [1:0]       r0_req = '0, r0_we = '0, r1_req = '0, r1_we = '0;
    logic [1:0][19:0] r0_addr = '0, r1_addr = '0;
    logic [1:0][15:0] r0_wdata = '0, r1_wdata = '0;
    logic [1:0]       r0_ack, r1_ack, mem_read, mem_write, busy, owner;
    logic [1:0][19:0] mem_addr;
    logic [1:0][15:0] mem_wdata, r0_rdata, r1_rdata;

    function automatic logic [15:0] init_val(logic [19:0] a);
        return (a == 20'h00010) ? 16'hBEEF : (a[15:0] ^ 16'h5A5A);
    endfunction

    task automatic chk(string nm, int g, logic [31:0] a, logic [31:0] e);
        n_cmp++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s u%0d: got %0h expected %0h at %0t",
                     nm, g, a, e, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : gen_u
        localparam int W = (g == 0) ? 2 : 0;
        logic [15:0] mrd = '0;
        logic [15:0] bmem [logic [19:0]];

        mem_bus_arbiter #(
            .ADDR_WIDTH(20), .DATA_WIDTH(16), .WAIT_CYCLES(W)
        ) u_dut (
            .clk(clk), .reset(reset),
            .r0_req(r0_req[g]), .r0_we(r0_we[g]),
            .r0_addr(r0_addr[g]), .r0_wdata(r0_wdata[g]),
            .r0_rdata(r0_rdata[g]), .r0_ack(r0_ack[g]),
            .r1_req(r1_req[g]), .r1_we(r1_we[g]),
            .r1_addr(r1_addr[g]), .r1_wdata(r1_wdata[g]),
            .r1_rdata(r1_rdata[g]), .r1_ack(r1_ack[g]),
            .mem_addr(mem_addr[g]), .mem_wdata(mem_wdata[g]),
            .mem_rdata(mrd), .mem_read(mem_read[g]),
            .mem_write(mem_write[g]), .busy(busy[g]), .owner(owner[g])
        );

        // Bench memory: combinational read refreshed mid-cycle.
        always @(negedge clk)
            mrd = bmem.exists(mem_addr[g]) ? bmem[mem_addr[g]]
                                           : init_val(mem_addr[g]);
        always @(posedge clk)
            if (mem_write[g]) bmem[mem_addr[g]] = mem_wdata[g];

        // Model: a transaction granted at the end of cycle s strobes in
        // cycles s+1..s+W+1, acks in s+W+2, bus free again from s+W+3.
        int          cyc = 0, s = 0, free_at = 0;
        bit          act = 0, t_own = 0, t_we = 0, last = 1, m_own = 1;
        logic [19:0] m_addr = '0;
        logic [15:0] m_wd = '0, m_rd0 = '0, m_rd1 = '0;
        logic [15:0] mmem [logic [19:0]];
        logic [15:0] rv;

        always @(posedge clk or posedge reset) begin
            if (reset) begin
                cyc = 0; s = 0; free_at = 0; act = 0;
                last = 1; m_own = 1; m_addr = '0; m_wd = '0;
                m_rd0 = '0; m_rd1 = '0;
            end else begin
                if (act && cyc == s + W + 1) begin
                    if (t_we) mmem[m_addr] = m_wd;
                    else begin
                        rv = mmem.exists(m_addr) ? mmem[m_addr]
                                                 : init_val(m_addr);
                        if (t_own) m_rd1 = rv;
                        else m_rd0 = rv;
                    end
                end
                if (cyc >= free_at && (r0_req[g] || r1_req[g])) begin
                    t_own = (r0_req[g] && r1_req[g]) ? !last : r1_req[g];
                    last = t_own;
                    m_own = t_own;
                    t_we = t_own ? r1_we[g] : r0_we[g];
                    m_addr = t_own ? r1_addr[g] : r0_addr[g];
                    m_wd = t_own ? r1_wdata[g] : r0_wdata[g];
                    s = cyc; act = 1; free_at = cyc + W + 3;
                end
                cyc++;
            end
        end

        bit in_acc, in_ack;
        always @(negedge clk) if (chk_en) begin
            in_acc = act && cyc >= s + 1 && cyc <= s + W + 1;
            in_ack = act && cyc == s + W + 2;
            chk("m_read", g, mem_read[g], in_acc && !t_we);
            chk("m_write", g, mem_write[g], in_acc && t_we);
            chk("m_ack0", g, r0_ack[g], in_ack && !t_own);
            chk("m_ack1", g, r1_ack[g], in_ack && t_own);
            chk("m_busy", g, busy[g], in_acc || in_ack);
            chk("m_owner", g, owner[g], m_own);
            chk("m_addr", g, mem_addr[g], m_addr);
            chk("m_wdata", g, mem_wdata[g], m_wd);
            chk("m_rdata0", g, r0_rdata[g], m_rd0);
            chk("m_rdata1", g, r1_rdata[g], m_rd1);
        end
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic issue(int g, bit who, bit we,
                         logic [19:0] a, logic [15:0] d);
        if (who) begin
            r1_we[g] = we; r1_addr[g] = a; r1_wdata[g] = d; r1_req[g] = 1;
        end else begin
            r0_we[g] = we; r0_addr[g] = a; r0_wdata[g] = d; r0_req[g] = 1;
        end
    endtask

    task automatic drop(int g, bit who);
        if (who) r1_req[g] = 0;
        else r0_req[g] = 0;
    endtask

    task automatic wait_ack(int g, bit who, output int lat);
        lat = 0;
        do begin
            step();
            lat++;
        end while (!(who ? r1_ack[g] : r0_ack[g]) && lat < 30);
        chk("ack_seen", g, who ? r1_ack[g] : r0_ack[g], 1);
    endtask

    initial begin
        int seen[$];
        int when[$];
        int k;
        int lat;

        @(posedge clk);
        chk_en = 1;
        repeat (2) @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            chk("rst_owner", g, owner[g], 1);
            chk("rst_busy", g, busy[g], 0);
            chk("rst_rdata", g, r0_rdata[g], 0);
        end
        @(posedge clk); #1 reset = 0;

        // Tie after reset: r0 first, then strict alternation.
        @(posedge clk); #1;
        issue(0, 0, 0, 20'h00100, 16'h0);
        issue(0, 1, 0, 20'h00200, 16'h0);
        k = 0;
        while (seen.size() < 4 && k < 40) begin
            step();
            k++;
            if (r0_ack[0]) begin seen.push_back(0); when.push_back(k); end
            if (r1_ack[0]) begin seen.push_back(1); when.push_back(k); end
        end
        chk("rr_count", 0, seen.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < seen.size()) begin
                chk("rr_owner", 0, seen[i], i % 2);
                chk("rr_cycle", 0, when[i], 4 + 5 * i);
            end
        end
        @(posedge clk); #1;
        drop(0, 0);
        drop(0, 1);

        // Single read.
        @(posedge clk); #1;
        issue(0, 0, 0, 20'h00010, 16'h0);
        for (int c = 1; c <= 4; c++) begin
            step();
            chk("rd_strobe", 0, mem_read[0], c <= 3);
            chk("rd_ack0", 0, r0_ack[0], c == 4);
            chk("rd_ack1", 0, r1_ack[0], 0);
            if (c <= 3) chk("rd_addr", 0, mem_addr[0], 20'h00010);
        end
        chk("rd_data", 0, r0_rdata[0], 16'hBEEF);
        @(posedge clk); #1 drop(0, 0);

        // r1 write then read back.
        @(posedge clk); #1;
        issue(0, 1, 1, 20'h0ABCD, 16'h1234);
        for (int c = 1; c <= 4; c++) begin
            step();
            chk("wr_strobe", 0, mem_write[0], c <= 3);
            chk("wr_noread", 0, mem_read[0], 0);
            chk("wr_wdata", 0, mem_wdata[0], 16'h1234);
            chk("wr_rdata", 0, r1_rdata[0], 16'h585A);
            chk("wr_ack1", 0, r1_ack[0], c == 4);
        end
        @(posedge clk); #1 drop(0, 1);
        @(posedge clk); #1;
        issue(0, 1, 0, 20'h0ABCD, 16'h0);
        wait_ack(0, 1, lat);
        chk("rb_lat", 0, lat, 4);
        chk("rb_data", 0, r1_rdata[0], 16'h1234);
        @(posedge clk); #1 drop(0, 1);

        // Address change during ACCESS is ignored.
        @(posedge clk); #1;
        issue(0, 0, 0, 20'h00001, 16'h0);
        step();
        chk("fc_addr1", 0, mem_addr[0], 20'h00001);
        @(posedge clk); #1 r0_addr[0] = 20'h00002;
        @(negedge clk);
        chk("fc_addr2", 0, mem_addr[0], 20'h00001);
        step();
        chk("fc_addr3", 0, mem_addr[0], 20'h00001);
        step();
        chk("fc_ack", 0, r0_ack[0], 1);
        chk("fc_data", 0, r0_rdata[0], 16'h5A5B);
        @(posedge clk); #1 drop(0, 0);

        // Reset during cycle 2 of a read.
        @(posedge clk); #1;
        issue(0, 0, 0, 20'h00040, 16'h0);
        step();
        @(posedge clk); #2 reset = 1;
        #1;
        chk("mr_read", 0, mem_read[0], 0);
        chk("mr_ack", 0, r0_ack[0], 0);
        chk("mr_rdata", 0, r0_rdata[0], 0);
        chk("mr_owner", 0, owner[0], 1);
        chk("mr_busy", 0, busy[0], 0);
        drop(0, 0);
        repeat (2) @(posedge clk);
        #1 reset = 0;
        @(posedge clk); #1;
        issue(0, 0, 0, 20'h00040, 16'h0);
        wait_ack(0, 0, lat);
        chk("mr_lat", 0, lat, 4);
        chk("mr_data", 0, r0_rdata[0], 16'h5A1A);
        @(posedge clk); #1 drop(0, 0);

        // Zero wait states: single read.
        @(posedge clk); #1;
        issue(1, 0, 0, 20'h00010, 16'h0);
        step();
        chk("z_read1", 1, mem_read[1], 1);
        chk("z_ack1", 1, r0_ack[1], 0);
        step();
        chk("z_read2", 1, mem_read[1], 0);
        chk("z_ack2", 1, r0_ack[1], 1);
        chk("z_data", 1, r0_rdata[1], 16'hBEEF);
        @(posedge clk); #1 drop(1, 0);

        // Zero wait states: request held across ack.
        @(posedge clk); #1;
        issue(1, 0, 0, 20'h00030, 16'h0);
        for (int c = 1; c <= 5; c++) begin
            step();
            chk("bb_read", 1, mem_read[1], c == 1 || c == 4);
            chk("bb_ack", 1, r0_ack[1], c == 2 || c == 5);
            chk("bb_busy", 1, busy[1], c != 3);
        end
        chk("bb_data", 1, r0_rdata[1], 16'h5A6A);
        @(posedge clk); #1 drop(1, 0);
        repeat (3) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_fail);
        $finish;
    end

endmodule
